// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   - Datapath widths (instruction, PC, register index).
//   - Bit positions of the fields that decode pulls out of an instruction.
//   - NOP encoding used for pipeline bubbles.
//   - Fetch FSM state type.
package fetch_pkg;

  localparam int INSTR_W = 16;
  localparam int PC_W    = 16;
  localparam int REG_W   = 3;

  localparam int OPC_MSB   = 15;
  localparam int OPC_LSB   = 12;
  localparam int RS_MSB    = 11;
  localparam int RS_LSB    = 9;
  localparam int RT_MSB    = 8;
  localparam int RT_LSB    = 6;
  localparam int RD_MSB    = 5;
  localparam int RD_LSB    = 3;
  localparam int FUNCT_MSB = 1;
  localparam int FUNCT_LSB = 0;
  localparam int IMM6_MSB  = 5;
  localparam int IMM6_LSB  = 0;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

  // EMPTY: nothing in flight, skid empty
  // FETCH: one request in flight
  // HELD : skid full, nothing in flight
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FETCH = 2'd1,
    HELD  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register with load/hold/flush control and decode field split.
// Ports:
//   clock, reset        - clock, async active-high reset
//   i_load, i_flush     - load new instruction / insert bubble (flush wins)
//   i_instr, i_pc       - instruction and its word address to load
//   o_valid, o_pc, o_pc_plus1, o_instr - register contents
//   o_opcode, o_rs, o_rt, o_rd, o_funct, o_imm6 - combinational field slices
module if_id_register
  import fetch_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               i_load,
  input  logic               i_flush,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic [PC_W-1:0]    i_pc,
  output logic               o_valid,
  output logic [PC_W-1:0]    o_pc,
  output logic [PC_W-1:0]    o_pc_plus1,
  output logic [INSTR_W-1:0] o_instr,
  output logic [3:0]         o_opcode,
  output logic [REG_W-1:0]   o_rs,
  output logic [REG_W-1:0]   o_rt,
  output logic [REG_W-1:0]   o_rd,
  output logic [1:0]         o_funct,
  output logic [5:0]         o_imm6
);

  logic               r_valid;
  logic [INSTR_W-1:0] r_instr;
  logic [PC_W-1:0]    r_pc;

  // A flush keeps the stale PC; it is meaningless while r_valid is low.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_instr <= NOP_INSTR;
      r_pc    <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
      r_instr <= NOP_INSTR;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_instr <= i_instr;
      r_pc    <= i_pc;
    end
  end

  assign o_valid    = r_valid;
  assign o_pc       = r_pc;
  assign o_pc_plus1 = r_pc + 16'd1;
  assign o_instr    = r_instr;

  // rd and imm6 overlap; decode picks one by instruction type.
  assign o_opcode = r_instr[OPC_MSB:OPC_LSB];
  assign o_rs     = r_instr[RS_MSB:RS_LSB];
  assign o_rt     = r_instr[RT_MSB:RT_LSB];
  assign o_rd     = r_instr[RD_MSB:RD_LSB];
  assign o_funct  = r_instr[FUNCT_MSB:FUNCT_LSB];
  assign o_imm6   = r_instr[IMM6_MSB:IMM6_LSB];

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: program counter, fixed one-cycle-latency imem
// interface, one-entry skid buffer for decode stalls, branch/jump redirect.
// Ports:
//   clock, reset           - clock, async active-high reset
//   stall                  - decode cannot accept; IF/ID and PC hold
//   redirect, redirect_pc  - taken branch/jump and its target word address
//   imem_req, imem_addr    - fetch request and word address
//   imem_rdata             - instruction, valid the cycle after a request
//   if_valid, if_pc, if_pc_plus1, if_instr - IF/ID register contents
//   opcode, rs, rt, rd, funct, signalToExtend - IF/ID instruction fields
module if_stage
  import fetch_pkg::*;
#(
  parameter logic [15:0] PC_RESET = 16'h0000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               stall,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  output logic [PC_W-1:0]    if_pc,
  output logic [PC_W-1:0]    if_pc_plus1,
  output logic [INSTR_W-1:0] if_instr,
  output logic [3:0]         opcode,
  output logic [REG_W-1:0]   rs,
  output logic [REG_W-1:0]   rt,
  output logic [REG_W-1:0]   rd,
  output logic [1:0]         funct,
  output logic [5:0]         signalToExtend
);

  fetch_state_e       r_state;
  fetch_state_e       w_state_next;
  logic [PC_W-1:0]    r_pc;
  logic [PC_W-1:0]    r_fl_pc;       // address of the request in flight
  logic [INSTR_W-1:0] r_skid_instr;
  logic [PC_W-1:0]    r_skid_pc;

  logic               w_req;
  logic [PC_W-1:0]    w_addr;
  logic               w_load;
  logic               w_flush;
  logic               w_skid_we;
  logic [INSTR_W-1:0] w_load_instr;
  logic [PC_W-1:0]    w_load_pc;

  // Never request while stalled (unless redirecting), so the skid cannot overflow.
  assign w_req     = !reset && (redirect || !stall);
  assign w_addr    = redirect ? redirect_pc : r_pc;
  assign imem_req  = w_req;
  assign imem_addr = w_addr;

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_flush      = 1'b0;
    w_skid_we    = 1'b0;
    w_load_instr = imem_rdata;
    w_load_pc    = r_fl_pc;
    if (redirect) begin
      // Drop in-flight data and skid; the target request is issued this cycle.
      w_state_next = FETCH;
      w_flush      = 1'b1;
    end else begin
      case (r_state)
        EMPTY: begin
          if (!stall) begin
            w_state_next = FETCH;
            w_flush      = 1'b1;
          end
        end
        FETCH: begin
          if (!stall) begin
            w_load = 1'b1;
          end else begin
            w_skid_we    = 1'b1;
            w_state_next = HELD;
          end
        end
        HELD: begin
          if (!stall) begin
            w_load       = 1'b1;
            w_load_instr = r_skid_instr;
            w_load_pc    = r_skid_pc;
            w_state_next = FETCH;
          end
        end
        default: w_state_next = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= EMPTY;
      r_pc         <= PC_RESET;
      r_fl_pc      <= '0;
      r_skid_instr <= NOP_INSTR;
      r_skid_pc    <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_req) begin
        r_pc    <= w_addr + 16'd1;
        r_fl_pc <= w_addr;
      end
      if (redirect) begin
        r_skid_instr <= NOP_INSTR;
        r_skid_pc    <= '0;
      end else if (w_skid_we) begin
        r_skid_instr <= imem_rdata;
        r_skid_pc    <= r_fl_pc;
      end
    end
  end

  if_id_register u_if_id (
    .clock      (clock),
    .reset      (reset),
    .i_load     (w_load),
    .i_flush    (w_flush),
    .i_instr    (w_load_instr),
    .i_pc       (w_load_pc),
    .o_valid    (if_valid),
    .o_pc       (if_pc),
    .o_pc_plus1 (if_pc_plus1),
    .o_instr    (if_instr),
    .o_opcode   (opcode),
    .o_rs       (rs),
    .o_rt       (rt),
    .o_rd       (rd),
    .o_funct    (funct),
    .o_imm6     (signalToExtend)
  );

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata = '0;
  logic        if_valid;
  logic [15:0] if_pc, if_pc_plus1, if_instr;
  logic [3:0]  opcode;
  logic [2:0]  rs, rt, rd;
  logic [1:0]  funct;
  logic [5:0]  signalToExtend;

  int n_vec = 0;
  int n_err = 0;

  if_stage #(.PC_RESET(16'h0010)) dut (
    .clock          (clock),
    .reset          (reset),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_pc_plus1    (if_pc_plus1),
    .if_instr       (if_instr),
    .opcode         (opcode),
    .rs             (rs),
    .rt             (rt),
    .rd             (rd),
    .funct          (funct),
    .signalToExtend (signalToExtend)
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] mem_f(input logic [15:0] a);
    return a ^ 16'hA5A5;
  endfunction

  // Instruction memory: one-cycle read latency.
  always @(posedge clock) if (imem_req) imem_rdata <= mem_f(imem_addr);

  // Reference model: requests become deliverable one edge after issue and
  // leave in order whenever decode accepts; a redirect discards everything.
  logic [15:0] m_pc;
  logic [15:0] m_q[$];
  logic        m_valid;
  logic [15:0] m_opc;

  task automatic model_reset();
    m_pc = 16'h0010; m_q.delete(); m_valid = 1'b0; m_opc = '0;
  endtask

  task automatic drive(input logic s, input logic r, input logic [15:0] rpc);
    stall = s; redirect = r; redirect_pc = rpc;
    @(negedge clock);
  endtask

  task automatic tick();
    @(posedge clock);
    if (reset) model_reset();
    else if (redirect) begin
      m_q.delete(); m_valid = 1'b0; m_q.push_back(redirect_pc); m_pc = redirect_pc + 16'd1;
    end else if (!stall) begin
      if (m_q.size() > 0) begin m_valid = 1'b1; m_opc = m_q.pop_front(); end
      else m_valid = 1'b0;
      m_q.push_back(m_pc); m_pc = m_pc + 16'd1;
    end
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %0h want 0", imem_req); end
    n_vec++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0h want 0", if_valid); end
    n_vec++; if (if_instr !== 16'h0) begin n_err++; $display("FAIL reset_instr: got %h want 0000", if_instr); end
    n_vec++; if (if_pc !== 16'h0) begin n_err++; $display("FAIL reset_pc: got %h want 0000", if_pc); end
    tick();
    reset = 1'b0;
    drive(0, 0, 0);
    n_vec++; if (imem_req !== 1'b1 || imem_addr !== 16'h0010)
      begin n_err++; $display("FAIL first_req: got %0h/%h want 1/0010", imem_req, imem_addr); end
    tick();
    drive(0, 0, 0);
    n_vec++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL first_bubble: got %0h want 0", if_valid); end
    tick();
    drive(0, 0, 0);
    n_vec++; if (if_valid !== 1'b1 || if_pc !== 16'h0010 || if_instr !== 16'hA5B5)
      begin n_err++; $display("FAIL first_instr: got %0h/%h/%h want 1/0010/a5b5", if_valid, if_pc, if_instr); end
  endtask

  task automatic test_stream();
    logic [15:0] e;
    for (int i = 1; i < 8; i++) begin
      tick();
      drive(0, 0, 0);
      e = mem_f(16'h0010 + 16'(i));
      n_vec++; if (if_valid !== 1'b1 || if_pc !== 16'h0010 + 16'(i) || if_instr !== e)
        begin n_err++; $display("FAIL stream_pc: got %0h/%h/%h want 1/%h/%h", if_valid, if_pc, if_instr, 16'h0010 + 16'(i), e); end
      n_vec++; if ({opcode, rs, rt, rd, funct, signalToExtend} !== {e[15:12], e[11:9], e[8:6], e[5:3], e[1:0], e[5:0]})
        begin n_err++; $display("FAIL stream_fields: got %h %h %h %h %h %h for instr %h", opcode, rs, rt, rd, funct, signalToExtend, e); end
      n_vec++; if (if_pc_plus1 !== if_pc + 16'd1 || if_pc_plus1 !== 16'h0011 + 16'(i))
        begin n_err++; $display("FAIL stream_plus1: got %h want %h", if_pc_plus1, 16'h0011 + 16'(i)); end
    end
  endtask

  task automatic test_stall();
    logic [15:0] p, ins;
    tick();
    drive(1, 0, 0);
    p = if_pc; ins = if_instr;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) drive(1, 0, 0);
      n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL stall_req: got %0h want 0", imem_req); end
      n_vec++; if (if_pc !== p || if_instr !== ins || if_valid !== 1'b1)
        begin n_err++; $display("FAIL stall_hold: got %h/%h want %h/%h", if_pc, if_instr, p, ins); end
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0);
      n_vec++; if (if_valid !== 1'b1 || if_pc !== p + 16'(i) || if_instr !== mem_f(p + 16'(i)))
        begin n_err++; $display("FAIL stall_release: got %0h/%h want 1/%h", if_valid, if_pc, p + 16'(i)); end
      tick();
    end
  endtask

  task automatic test_redirect();
    drive(0, 1, 16'h0100);
    n_vec++; if (imem_req !== 1'b1 || imem_addr !== 16'h0100)
      begin n_err++; $display("FAIL redir_addr: got %0h/%h want 1/0100", imem_req, imem_addr); end
    tick();
    drive(0, 0, 0);
    n_vec++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL redir_bubble: got %0h want 0", if_valid); end
    tick();
    drive(0, 0, 0);
    n_vec++; if (if_valid !== 1'b1 || if_pc !== 16'h0100 || if_instr !== mem_f(16'h0100))
      begin n_err++; $display("FAIL redir_target: got %0h/%h want 1/0100", if_valid, if_pc); end
    tick();
  endtask

  task automatic test_redirect_held();
    drive(1, 0, 0); tick();
    drive(1, 0, 0); tick();
    drive(1, 1, 16'h0200);
    n_vec++; if (imem_req !== 1'b1 || imem_addr !== 16'h0200)
      begin n_err++; $display("FAIL held_redir_addr: got %0h/%h want 1/0200", imem_req, imem_addr); end
    tick();
    drive(1, 0, 0);
    n_vec++; if (if_valid !== 1'b0 || if_instr !== 16'h0)
      begin n_err++; $display("FAIL held_flush: got %0h/%h want 0/0000", if_valid, if_instr); end
    tick();
    drive(0, 0, 0);
    n_vec++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL held_still_empty: got %0h want 0", if_valid); end
    tick();
    drive(0, 0, 0);
    n_vec++; if (if_valid !== 1'b1 || if_pc !== 16'h0200)
      begin n_err++; $display("FAIL held_target: got %0h/%h want 1/0200", if_valid, if_pc); end
    tick();
  endtask

  task automatic test_wrap();
    drive(0, 1, 16'hFFFF); tick();
    drive(0, 0, 0);
    n_vec++; if (imem_addr !== 16'h0000) begin n_err++; $display("FAIL wrap_addr: got %h want 0000", imem_addr); end
    tick();
    drive(0, 0, 0);
    n_vec++; if (if_valid !== 1'b1 || if_pc !== 16'hFFFF || if_pc_plus1 !== 16'h0000)
      begin n_err++; $display("FAIL wrap_ffff: got %0h/%h/%h want 1/ffff/0000", if_valid, if_pc, if_pc_plus1); end
    tick();
    drive(0, 0, 0);
    n_vec++; if (if_valid !== 1'b1 || if_pc !== 16'h0000 || if_instr !== 16'hA5A5)
      begin n_err++; $display("FAIL wrap_0000: got %0h/%h/%h want 1/0000/a5a5", if_valid, if_pc, if_instr); end
    tick();
  endtask

  task automatic test_async_reset();
    drive(0, 0, 0);
    n_vec++; if (if_valid !== 1'b1) begin n_err++; $display("FAIL areset_pre: got %0h want 1", if_valid); end
    reset = 1'b1;
    #1;
    n_vec++; if (if_valid !== 1'b0 || imem_req !== 1'b0)
      begin n_err++; $display("FAIL areset_clear: got %0h/%0h want 0/0", if_valid, imem_req); end
    tick();
    reset = 1'b0;
    drive(0, 0, 0);
    n_vec++; if (imem_req !== 1'b1 || imem_addr !== 16'h0010)
      begin n_err++; $display("FAIL areset_refetch: got %0h/%h want 1/0010", imem_req, imem_addr); end
    tick();
  endtask

  task automatic test_random();
    logic        s, r, er;
    logic [15:0] rpc, e;
    for (int i = 0; i < 600; i++) begin
      s   = ($urandom_range(0, 99) < 30);
      r   = ($urandom_range(0, 99) < 8);
      rpc = ($urandom_range(0, 3) == 0) ? 16'hFFFE + 16'($urandom_range(0, 2)) : 16'($urandom);
      drive(s, r, rpc);
      er = r | !s;
      e  = m_valid ? mem_f(m_opc) : 16'h0000;
      n_vec++; if (imem_req !== er) begin n_err++; $display("FAIL rnd_req: cyc %0d got %0h want %0h", i, imem_req, er); end
      if (er) begin
        n_vec++; if (imem_addr !== (r ? rpc : m_pc))
          begin n_err++; $display("FAIL rnd_addr: cyc %0d got %h want %h", i, imem_addr, r ? rpc : m_pc); end
      end
      n_vec++; if (if_valid !== m_valid || if_instr !== e)
        begin n_err++; $display("FAIL rnd_out: cyc %0d got %0h/%h want %0h/%h", i, if_valid, if_instr, m_valid, e); end
      if (m_valid) begin
        n_vec++; if (if_pc !== m_opc || if_pc_plus1 !== m_opc + 16'd1)
          begin n_err++; $display("FAIL rnd_pc: cyc %0d got %h/%h want %h", i, if_pc, if_pc_plus1, m_opc); end
        n_vec++; if ({opcode, rs, rt, rd, funct, signalToExtend} !== {e[15:12], e[11:9], e[8:6], e[5:3], e[1:0], e[5:0]})
          begin n_err++; $display("FAIL rnd_fields: cyc %0d instr %h", i, e); end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_held();
    test_wrap();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the 16-bit pipelined processor, sitting directly upstream of the decode (ID) stage. It owns the program counter, drives a fixed-latency instruction memory, absorbs decode stalls with a one-entry skid buffer, and handles branch/jump redirects. It holds the IF/ID pipeline register and splits it into the fields decode consumes: rs, rt, rd, funct and the 6-bit immediate.

## Interface
- PC_RESET, 16'h0000, PC value loaded on reset (word address)
- clock  in  1  rising-edge clock, the only clock
- reset  in  1  asynchronous, active-high; clears all state
- stall  in  1  decode cannot accept; IF/ID holds, PC holds
- redirect  in  1  taken branch/jump; flush and refetch
- redirect_pc  in  16  target word address, valid with redirect
- imem_req  out  1  fetch request this cycle
- imem_addr  out  16  fetch word address
- imem_rdata  in  16  instruction, valid exactly one cycle after a request
- if_valid  out  1  IF/ID holds a real instruction
- if_pc  out  16  address of the IF/ID instruction
- if_pc_plus1  out  16  if_pc + 1, mod 2^16
- if_instr  out  16  IF/ID instruction (16'h0000 = NOP bubble)
- opcode  out  4  if_instr[15:12]
- rs  out  3  if_instr[11:9]
- rt  out  3  if_instr[8:6]
- rd  out  3  if_instr[5:3]
- funct  out  2  if_instr[1:0]
- signalToExtend  out  6  if_instr[5:0]

## Operation
- Reset: pc=PC_RESET; state EMPTY; skid cleared; if_valid=0, if_instr=0, if_pc=0. imem_req=0 while reset is asserted.
- Request rule: imem_req = redirect | !stall. imem_addr = redirect ? redirect_pc : pc.
- PC update: on redirect, pc <= redirect_pc+1. Otherwise, on a request, pc <= pc+1. Otherwise pc holds. Word addressing; 16'hFFFF+1 wraps to 16'h0000.
- Response capture: imem_rdata is valid in the cycle after a request (in-flight).
  - If that cycle has no stall and no redirect: IF/ID <= {rdata, its pc}, if_valid=1.
  - If stall and no redirect: the response goes into the skid (instr, pc). IF/ID is unchanged.
- States:
  - EMPTY: nothing in flight, skid empty.
  - FETCH: one request in flight.
  - HELD: skid full, nothing in flight.
- Transitions (redirect is the highest priority):
  - Any state, redirect=1 → FETCH. Drop any in-flight data (not captured) and clear the skid. IF/ID <= NOP with if_valid=0, even if stall=1.
  - EMPTY: !stall → FETCH. If no request is issued, IF/ID gets a bubble (if_valid=0) unless stall=1, in which case it holds.
  - FETCH: !stall → capture into IF/ID, new request issued, stay in FETCH. stall → response into skid → HELD.
  - HELD: stall → hold. !stall → IF/ID <= skid, new request issued → FETCH.
- Fields are combinational slices of the IF/ID instruction register. rd and signalToExtend overlap by design; decode selects between them by instruction type.

## Timing
- Fetch latency: a request in cycle N makes the instruction visible on the IF/ID outputs in cycle N+2.
- Steady state is one instruction per cycle. Releasing a stall produces no bubble, because the skid drains in the release cycle.
- Redirect in cycle N:
  - imem_addr=redirect_pc in N.
  - if_valid=0 in N+1.
  - Target instruction is valid in N+2.
  - Exactly one bubble per redirect.
- Stall only takes effect on edges. Outputs are stable for the whole stalled cycle.
- Reset mid-operation: state returns to the reset values asynchronously. The first request after reset deassertion fetches PC_RESET.
- At most one request is ever outstanding. The skid never overflows, because imem_req=0 whenever stall=1 and redirect=0.

## Structure
- Shared package fetch_pkg holds:
  - INSTR_W=16, PC_W=16, REG_W=3.
  - Field bit positions for opcode/rs/rt/rd/funct/imm6.
  - NOP_INSTR=16'h0000.
  - The state enum {EMPTY, FETCH, HELD}.
- Sub-module if_id_register: the IF/ID pipeline register with load/hold/flush controls, plus the field split. if_stage contains the PC, FSM and skid.

## Test plan
- Reset with PC_RESET=16'h0010, memory mem[a]=a^16'hA5A5: first request addr 16'h0010. if_valid=1 two cycles after reset deasserts, if_pc=16'h0010, if_instr=16'hA5B5.
- Stream: 8 cycles with no stall. if_pc increments 0x10..0x17 on consecutive cycles with no gaps. rs/rt/rd/funct/signalToExtend match the instruction slices.
- Stall for 3 cycles starting the cycle after a request:
  - imem_req=0 for those cycles.
  - The IF/ID contents hold.
  - On release, the next IF/ID is the skid instruction, then continuous addresses follow. No instruction is lost or duplicated.
- Redirect to 16'h0100 while FETCH:
  - if_valid=0 the next cycle.
  - if_pc=16'h0100 the cycle after.
  - The in-flight old instruction never appears.
- Redirect with stall=1 and HELD: the skid and IF/ID are flushed (if_valid=0), and the next valid instruction is at redirect_pc.
- Wrap and async reset:
  - Redirect to 16'hFFFF: the fetched addresses run 16'hFFFF then 16'h0000, and if_pc_plus1 for 16'hFFFF is 16'h0000.
  - Asserting reset between clock edges clears if_valid immediately.
